// File: rtl/writeback_stage_pkg.sv
// Shared types and constants for the writeback stage and its register file.
// The optional retired-instruction counter is enabled by defining WB_INSTRET_EN.
package writeback_stage_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned NREG = 32;

   typedef logic [4:0] reg_addr_t;

   typedef enum logic {
      WB_RUN,
      WB_FLUSH
   } wb_state_e;

   typedef struct packed {
      reg_addr_t       rd;
      logic            we;
      logic [XLEN-1:0] value;
      logic            redirect;
      logic [XLEN-1:0] target;
   } wb_beat_t;

endpackage

// File: rtl/regfile_2r1w.sv
// General register file: one synchronous write port, two asynchronous read ports.
// Register x0 is hardwired to zero; every entry resets asynchronously to zero.
module regfile_2r1w
   import writeback_stage_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  reg_addr_t       waddr,
   input  logic [XLEN-1:0] wdata,
   input  reg_addr_t       raddr1,
   input  reg_addr_t       raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2
);

   logic [XLEN-1:0] rf_q [NREG];
   logic [XLEN-1:0] rf_d [NREG];

   always_comb begin
      rf_d = rf_q;
      if (we) begin
         rf_d[waddr] = wdata;
      end
      rf_d[0] = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_q <= '{default: '0};
      end else begin
         rf_q <= rf_d;
      end
   end

   assign rdata1 = (raddr1 == '0) ? '0 : rf_q[raddr1];
   assign rdata2 = (raddr2 == '0) ? '0 : rf_q[raddr2];

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: registers exec results, commits them to the register file, bypasses the
// pending beat to the read ports and squashes wrong-path beats after a redirect. WB_INSTRET_EN adds instret.
module writeback_stage
   import writeback_stage_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_valid,
   output logic            ex_ready,
   input  reg_addr_t       ex_rd,
   input  logic            ex_rd_we,
   input  logic [XLEN-1:0] ex_rd_value,
   input  logic            ex_redirect,
   input  logic [XLEN-1:0] ex_target,
   input  logic            wb_stall,
   input  reg_addr_t       rs1_addr,
   input  reg_addr_t       rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            flush
`ifdef WB_INSTRET_EN
   ,
   output logic [63:0]     instret
`endif
);

   wb_beat_t        wb_q, wb_d;
   logic            wb_valid_q, wb_valid_d;
   wb_state_e       state_q, state_d;
   logic [2:0]      flush_cnt_q, flush_cnt_d;
   logic            commit, commit_redirect, capture;
   logic [XLEN-1:0] rf_rdata1, rf_rdata2;

   assign ex_ready        = !wb_stall;
   assign commit          = wb_valid_q && !wb_stall;
   assign commit_redirect = commit && wb_q.redirect;
   // A beat arriving alongside a committing redirect is on the wrong path.
   assign capture         = ex_valid && ex_ready && (state_q == WB_RUN) && !commit_redirect;

   always_comb begin
      wb_d       = wb_q;
      wb_valid_d = wb_valid_q;
      if (capture) begin
         wb_d.rd       = ex_rd;
         wb_d.we       = ex_rd_we;
         wb_d.value    = ex_rd_value;
         wb_d.redirect = ex_redirect;
         wb_d.target   = ex_target;
         wb_valid_d    = 1'b1;
      end else if (commit) begin
         wb_valid_d = 1'b0;
      end
   end

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      unique case (state_q)
         WB_RUN: begin
            if (commit_redirect) begin
               state_d     = WB_FLUSH;
               flush_cnt_d = 3'(FLUSH_CYCLES);
            end
         end
         WB_FLUSH: begin
            flush_cnt_d = flush_cnt_q - 3'd1;
            if (flush_cnt_q == 3'd1) begin
               state_d = WB_RUN;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_q        <= '0;
         wb_valid_q  <= 1'b0;
         state_q     <= WB_RUN;
         flush_cnt_q <= '0;
      end else begin
         wb_q        <= wb_d;
         wb_valid_q  <= wb_valid_d;
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   regfile_2r1w u_regfile (
      .clk    (clk),
      .rst    (rst),
      .we     (commit && wb_q.we),
      .waddr  (wb_q.rd),
      .wdata  (wb_q.value),
      .raddr1 (rs1_addr),
      .raddr2 (rs2_addr),
      .rdata1 (rf_rdata1),
      .rdata2 (rf_rdata2)
   );

   // Bypass stays active while stalled so consumers never see stale data.
   always_comb begin
      rs1_data = rf_rdata1;
      rs2_data = rf_rdata2;
      if (wb_valid_q && wb_q.we && (wb_q.rd == rs1_addr)) begin
         rs1_data = wb_q.value;
      end
      if (wb_valid_q && wb_q.we && (wb_q.rd == rs2_addr)) begin
         rs2_data = wb_q.value;
      end
      if (rs1_addr == '0) begin
         rs1_data = '0;
      end
      if (rs2_addr == '0) begin
         rs2_data = '0;
      end
   end

   assign redirect_valid = commit_redirect;
   assign redirect_pc    = wb_q.target;
   assign flush          = (state_q == WB_FLUSH);

`ifdef WB_INSTRET_EN
   logic [63:0] instret_q, instret_d;

   always_comb begin
      instret_d = instret_q + 64'(commit);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instret_q <= '0;
      end else begin
         instret_q <= instret_d;
      end
   end

   assign instret = instret_q;
`endif

endmodule
